// File: rtl/fc_out_writer.sv
// Post-processes PO accumulator sums (bias, shift, saturate, optional ReLU) and writes them to output RAM.
// Lane k is written 2+k cycles after the accepting edge; bursts arriving while busy are dropped and flagged.
module fc_out_writer #(
    parameter int PO          = 4,
    parameter int ACCUM_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_SHIFT  = 8,
    parameter int OUTNEURON   = 64,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        accum_valid,
    input  logic [PO*ACCUM_WIDTH-1:0]   accum_data,
    input  logic [PO*DATA_WIDTH-1:0]    bias_data,
    input  logic                        relu_en,
    output logic                        out_wren,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow_err
);

    localparam int LW = (PO > 1) ? $clog2(PO) : 1;
    localparam int CW = $clog2(OUTNEURON + 1);
    localparam int SW = ACCUM_WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, WRITE, FIN} state_t;

    state_t state, state_nxt;

    logic [PO*ACCUM_WIDTH-1:0]         acc_q;
    logic [PO*DATA_WIDTH-1:0]          bias_q;
    logic                              relu_q;
    logic [PO-1:0][DATA_WIDTH-1:0]     lane_q;
    logic [PO-1:0][DATA_WIDTH-1:0]     calc_res;
    logic [LW-1:0]                     lane_idx, idx_nxt, next_idx;
    logic [CW-1:0]                     wr_cnt, cnt_nxt;

    logic                              wren_nxt;
    logic [ADDR_WIDTH-1:0]             addr_nxt;
    logic [DATA_WIDTH-1:0]             data_nxt;
    logic                              busy_nxt, done_nxt, ovf_nxt;

    logic start, last_lane, frame_end;

    assign start     = (state == IDLE) && accum_valid && enable;
    assign last_lane = (lane_idx == LW'(PO - 1));
    assign frame_end = (wr_cnt == CW'(OUTNEURON));
    assign next_idx  = lane_idx + 1'b1;

    // Sum is formed one bit wider than the accumulator so the bias add cannot wrap before saturation.
    function automatic logic [DATA_WIDTH-1:0] lane_result(
        input logic [ACCUM_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0]  bias,
        input logic                   relu
    );
        logic signed [SW-1:0]  sum;
        logic signed [SW-1:0]  shifted;
        logic [DATA_WIDTH-1:0] sat;
        sum     = $signed({acc[ACCUM_WIDTH-1], acc})
                + ($signed({{(SW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< FRAC_SHIFT);
        shifted = sum >>> FRAC_SHIFT;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = shifted[DATA_WIDTH-1:0];
        end
        if (relu && sat[DATA_WIDTH-1]) begin
            sat = '0;
        end
        return sat;
    endfunction

    always_comb begin
        calc_res = '0;
        for (int k = 0; k < PO; k++) begin
            calc_res[k] = lane_result(acc_q[k*ACCUM_WIDTH +: ACCUM_WIDTH],
                                      bias_q[k*DATA_WIDTH +: DATA_WIDTH], relu_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   if (last_lane) state_nxt = frame_end ? FIN : IDLE;
            FIN:     state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values are prepared here and registered, so out_wren lines up exactly with the WRITE state.
    always_comb begin
        wren_nxt = 1'b0;
        addr_nxt = out_addr;
        data_nxt = out_data;
        cnt_nxt  = wr_cnt;
        idx_nxt  = lane_idx;
        ovf_nxt  = overflow_err | (accum_valid && ((state == CALC) || (state == WRITE)));
        case (state)
            CALC: begin
                wren_nxt = 1'b1;
                addr_nxt = ADDR_WIDTH'(wr_cnt);
                data_nxt = calc_res[0];
                cnt_nxt  = wr_cnt + 1'b1;
                idx_nxt  = '0;
            end
            WRITE: begin
                if (!last_lane) begin
                    wren_nxt = 1'b1;
                    addr_nxt = ADDR_WIDTH'(wr_cnt);
                    data_nxt = lane_q[next_idx];
                    cnt_nxt  = wr_cnt + 1'b1;
                    idx_nxt  = next_idx;
                end else if (frame_end) begin
                    cnt_nxt = '0;
                end
            end
            FIN: cnt_nxt = '0;
            default: ;
        endcase
        busy_nxt = (state_nxt == CALC) || (state_nxt == WRITE);
        done_nxt = (state_nxt == FIN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            bias_q       <= '0;
            relu_q       <= 1'b0;
            lane_q       <= '0;
            lane_idx     <= '0;
            wr_cnt       <= '0;
            out_wren     <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (start) begin
                acc_q  <= accum_data;
                bias_q <= bias_data;
                relu_q <= relu_en;
            end
            if (state == CALC) begin
                lane_q <= calc_res;
            end
            lane_idx     <= idx_nxt;
            wr_cnt       <= cnt_nxt;
            out_wren     <= wren_nxt;
            out_addr     <= addr_nxt;
            out_data     <= data_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            overflow_err <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fc_out_writer.sv
// Directed + randomized bench for fc_out_writer; expected lane values come from an integer-arithmetic model.
module tb_fc_out_writer;
    localparam int PO  = 4;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int FS  = 8;
    localparam int ON  = 64;
    localparam int ADW = 6;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   accum_valid;
    logic [PO-1:0][AW-1:0]  accum_data;
    logic [PO-1:0][DW-1:0]  bias_data;
    logic                   relu_en;
    logic                   out_wren;
    logic [ADW-1:0]         out_addr;
    logic [DW-1:0]          out_data;
    logic                   busy;
    logic                   done;
    logic                   overflow_err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fc_out_writer #(
        .PO(PO), .ACCUM_WIDTH(AW), .DATA_WIDTH(DW),
        .FRAC_SHIFT(FS), .OUTNEURON(ON), .ADDR_WIDTH(ADW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .accum_valid(accum_valid),
        .accum_data(accum_data), .bias_data(bias_data), .relu_en(relu_en),
        .out_wren(out_wren), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: real-valued fixed point, floor division by 2^FS, clamp, then ReLU.
    function automatic logic [DW-1:0] model(input logic [AW-1:0] acc, input logic [DW-1:0] b,
                                            input logic relu);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        s  = longint'($signed(acc)) + longint'($signed(b)) * (longint'(1) << FS);
        s  = s >>> FS;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return DW'(s);
    endfunction

    function automatic logic [AW-1:0] rand_acc();
        if ($urandom_range(0, 2) == 0) return AW'($urandom);
        return AW'(int'($urandom_range(0, 1 << 24)) - (1 << 23));
    endfunction

    // One burst: pulse, CALC cycle, PO write cycles, then the idle cycle in which the next pulse may start.
    task automatic burst(input logic [PO-1:0][AW-1:0] acc, input logic [PO-1:0][DW-1:0] b,
                         input logic relu, input logic [PO-1:0][DW-1:0] exp, input int base,
                         input logic exp_done, input string tag);
        enable      = 1'b1;
        accum_valid = 1'b1;
        accum_data  = acc;
        bias_data   = b;
        relu_en     = relu;
        tick();
        accum_valid = 1'b0;
        enable      = 1'($urandom_range(0, 1));
        accum_data  = {$urandom, $urandom, $urandom, $urandom};
        bias_data   = {$urandom, $urandom};
        relu_en     = ~relu;
        check({tag, ".calc_busy"}, 32'(busy), 32'd1);
        check({tag, ".calc_wren"}, 32'(out_wren), 32'd0);
        for (int k = 0; k < PO; k++) begin
            tick();
            check($sformatf("%s.wren%0d", tag, k), 32'(out_wren), 32'd1);
            check($sformatf("%s.addr%0d", tag, k), 32'(out_addr), 32'((base + k) % ON));
            check($sformatf("%s.data%0d", tag, k), 32'(out_data), 32'(exp[k]));
            check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
        end
        tick();
        check({tag, ".post_wren"}, 32'(out_wren), 32'd0);
        check({tag, ".post_busy"}, 32'(busy), 32'd0);
        check({tag, ".post_done"}, 32'(done), 32'(exp_done));
        check({tag, ".hold_addr"}, 32'(out_addr), 32'((base + PO - 1) % ON));
        check({tag, ".hold_data"}, 32'(out_data), 32'(exp[PO-1]));
        enable = 1'b1;
    endtask

    initial begin
        logic [PO-1:0][AW-1:0] acc;
        logic [PO-1:0][DW-1:0] b;
        logic [PO-1:0][DW-1:0] exp;
        logic                  relu;
        int                    nwr;

        reset = 1'b1; enable = 1'b0; accum_valid = 1'b0; relu_en = 1'b0;
        accum_data = '0; bias_data = '0;
        tick(); tick();
        check("rst.wren", 32'(out_wren), 32'd0);
        check("rst.addr", 32'(out_addr), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ovf",  32'(overflow_err), 32'd0);
        reset = 1'b0;
        tick();

        // Pulse while disabled is ignored.
        accum_valid = 1'b1; accum_data = {PO{32'h00001000}};
        tick();
        accum_valid = 1'b0;
        tick();
        check("dis.busy", 32'(busy), 32'd0);
        check("dis.wren", 32'(out_wren), 32'd0);
        enable = 1'b1;

        // Directed arithmetic, saturation and ReLU corners.
        acc = {32'hFFFFFE00, 32'h80000000, 32'h7FFFFF00, 32'h00000300};
        b   = {16'h0000, 16'h7FFF, 16'h7FFF, 16'h0001};
        burst(acc, b, 1'b0, {16'hFFFE, 16'h8000, 16'h7FFF, 16'h0004}, 0, 1'b0, "dir0");
        burst(acc, b, 1'b1, {16'h0000, 16'h0000, 16'h7FFF, 16'h0004}, 4, 1'b0, "dir1");

        // Second pulse during CALC is dropped and flagged.
        for (int k = 0; k < PO; k++) begin
            acc[k] = rand_acc(); b[k] = DW'($urandom); relu = 1'b0;
            exp[k] = model(acc[k], b[k], 1'b0);
        end
        accum_valid = 1'b1; accum_data = acc; bias_data = b; relu_en = 1'b0;
        tick();
        accum_data = {$urandom, $urandom, $urandom, $urandom}; relu_en = 1'b1;
        check("ovf.busy", 32'(busy), 32'd1);
        tick();
        accum_valid = 1'b0;
        check("ovf.flag", 32'(overflow_err), 32'd1);
        for (int k = 0; k < PO; k++) begin
            if (k > 0) tick();
            check($sformatf("ovf.wren%0d", k), 32'(out_wren), 32'd1);
            check($sformatf("ovf.addr%0d", k), 32'(out_addr), 32'(8 + k));
            check($sformatf("ovf.data%0d", k), 32'(out_data), 32'(exp[k]));
        end
        tick();
        check("ovf.busy_fall", 32'(busy), 32'd0);
        nwr = 0;
        repeat (6) begin
            if (out_wren) nwr++;
            tick();
        end
        check("ovf.extra_writes", 32'(nwr), 32'd0);
        check("ovf.sticky", 32'(overflow_err), 32'd1);

        // Reset during the lane-2 write.
        accum_valid = 1'b1; accum_data = acc; bias_data = b;
        tick();
        accum_valid = 1'b0;
        tick(); tick(); tick();
        check("rmid.wren2", 32'(out_wren), 32'd1);
        check("rmid.addr2", 32'(out_addr), 32'd14);
        reset = 1'b1;
        #1;
        check("rmid.wren", 32'(out_wren), 32'd0);
        check("rmid.addr", 32'(out_addr), 32'd0);
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.ovf",  32'(overflow_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        burst(acc, b, 1'b0, exp, 0, 1'b0, "rnext");

        // Full random frame after a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int n = 0; n < ON / PO; n++) begin
            relu = 1'($urandom_range(0, 1));
            for (int k = 0; k < PO; k++) begin
                acc[k] = rand_acc();
                b[k]   = DW'($urandom);
                exp[k] = model(acc[k], b[k], relu);
            end
            burst(acc, b, relu, exp, n * PO, (n == ON / PO - 1), $sformatf("frm%0d", n));
        end

        // A 17th burst after the frame is ignored without error.
        accum_valid = 1'b1; accum_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        accum_valid = 1'b0;
        nwr = 0;
        repeat (8) begin
            if (out_wren) nwr++;
            tick();
        end
        check("fin.writes", 32'(nwr), 32'd0);
        check("fin.done",   32'(done), 32'd1);
        check("fin.busy",   32'(busy), 32'd0);
        check("fin.ovf",    32'(overflow_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_out_writer.md
FC_OUT_WRITER -- requirements
Module: fc_out_writer

Interface
REQ-001 Parameter PO, default 4: output neurons produced per accumulation burst (lanes).
REQ-002 Parameter ACCUM_WIDTH, default 32: signed accumulator width per lane.
REQ-003 Parameter DATA_WIDTH, default 16: signed fixed-point output neuron width.
REQ-004 Parameter FRAC_SHIFT, default 8: fractional bits removed from accumulator.
REQ-005 Parameter OUTNEURON, default 64: output neurons per frame; multiple of PO.
REQ-006 Parameter ADDR_WIDTH, default 6: output RAM address width.
REQ-007 Ports: clock and reset come first; reset is asynchronous and active-high; clock is clock.
REQ-008 Port list, one line per port:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- enable  in  1  accept new bursts
- accum_valid  in  1  one-cycle pulse: accum_data holds PO finished sums
- accum_data  in  PO*ACCUM_WIDTH  lane k at bits [k*ACCUM_WIDTH +: ACCUM_WIDTH]
- bias_data  in  PO*DATA_WIDTH  per-lane signed bias, same packing, sampled with accum_valid
- relu_en  in  1  apply ReLU, sampled with accum_valid
- out_wren  out  1  output RAM write enable
- out_addr  out  ADDR_WIDTH  output RAM address
- out_data  out  DATA_WIDTH  output RAM write data
- busy  out  1  burst in progress
- done  out  1  frame complete, sticky
- overflow_err  out  1  burst dropped, sticky

Function
REQ-009 FSM states: IDLE, CALC, WRITE, FIN.
REQ-010 IDLE: accum_valid=1 and enable=1 at an edge -> capture accum_data, bias_data and relu_en; go to CALC.
- accum_valid with enable=0 in IDLE: ignored.
REQ-011 CALC: one cycle.
- Per lane: s = accum + (sign-extended bias << FRAC_SHIFT), computed at ACCUM_WIDTH+1 bits, no wrap.
- Arithmetic right shift by FRAC_SHIFT.
- Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- If captured relu_en=1, negative results -> 0.
- Register per-lane results; go to WRITE.
REQ-012 WRITE lasts exactly PO cycles; lane index k = 0..PO-1.
- Registered outputs: out_wren=1, out_data=lane k, out_addr = write counter.
- Write counter increments after each write.
REQ-013 Timing: accum_valid captured at edge T -> lane k write visible in cycle T+2+k.
REQ-014 After lane PO-1: if the write counter has reached OUTNEURON -> FIN, else -> IDLE.
- out_wren=0 in every state other than WRITE.
REQ-015 FIN: done=1, held until reset; write counter=0; accum_valid ignored, no error raised.
REQ-016 busy=1 in CALC and WRITE, else 0.
REQ-017 accum_valid=1 in CALC or WRITE: burst dropped, overflow_err set sticky; current sequence unaffected.
REQ-018 enable deasserted mid-burst: current burst completes normally.
REQ-019 out_addr, out_data hold their last values when out_wren=0.

Reset
REQ-020 Reset asserted:
- state=IDLE; write counter, lane registers and all outputs = 0 immediately (asynchronous).
- Applies mid-burst too: no further writes occur.
- The next frame restarts at address 0.

Verification
REQ-021 Arithmetic: lane0 accum=0x00000300, bias=0x0001, relu_en=0 -> out_data=0x0004 at addr 0, cycle T+2.
REQ-022 Saturation: lane1 accum=0x7FFFFF00, bias=0x7FFF -> 0x7FFF; accum=0x80000000 -> 0x8000.
REQ-023 ReLU: accum=0xFFFFFE00, bias=0 -> relu_en=1 gives 0x0000; relu_en=0 gives 0xFFFE.
REQ-024 Frame: 16 bursts spaced 6 cycles apart.
- 64 writes at addr 0..63, in order.
- done rises in the cycle after the last write; a 17th burst produces no write.
REQ-025 Overflow: second accum_valid one cycle after the first (during CALC).
- overflow_err=1.
- Exactly 4 writes occur with the first burst's data.
- busy falls after the 4th write.
REQ-026 Reset: assert reset during lane 2 write.
- out_wren=0 and out_addr=0 at once; busy=0.
- Next burst writes starting at addr 0.
